// File: rtl/mem_stage.sv
// mem_stage: stage-4 load/store unit and writeback select.
// Performs at most one bus access per entry into stage 4, then waits for the sequencer to move on.
module mem_stage #(
  parameter logic [2:0]  STAGE_MEM = 3'd4,
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [4:0]  IT_RTYPE  = 5'd1,
  parameter logic [4:0]  IT_ITYPE  = 5'd2,
  parameter logic [4:0]  IT_STYPE  = 5'd3,
  parameter logic [4:0]  IT_BTYPE  = 5'd4,
  parameter logic [4:0]  IT_UTYPE  = 5'd5,
  parameter logic [4:0]  IT_LTYPE  = 5'd6,
  parameter logic [4:0]  IT_JRTYPE = 5'd7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  stage_i,
  input  logic [31:0] ir_i,
  input  logic [4:0]  itype_i,
  input  logic [31:0] alu_y_i,
  input  logic [31:0] alu_pass_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_rd_o,
  output logic        wb_en_o,
  output logic        done_o,
  output logic        fault_o
);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, FINISH, HOLD} state_t;
  state_t state_q, state_d;

  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_ok_q, wb_ok_d, fault_q, fault_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        is_pass, is_load, is_store, legal, misaligned;
  logic [2:0]  f3;
  logic [3:0]  be_start;
  logic [31:0] wdata_start, load_val;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Only funct3 and rd are taken from the instruction word here.
  logic unused_ir;
  assign unused_ir = &{1'b0, ir_i[31:15], ir_i[6:0]};

  always_comb begin
    f3          = ir_i[14:12];
    is_pass     = (itype_i == IT_RTYPE) || (itype_i == IT_ITYPE) ||
                  (itype_i == IT_UTYPE) || (itype_i == IT_JRTYPE);
    is_load     = (itype_i == IT_LTYPE);
    is_store    = (itype_i == IT_STYPE);
    legal       = is_load ? ((f3[1:0] != 2'b11) && !(f3[2] && f3[1]))
                          : (!f3[2] && (f3[1:0] != 2'b11));
    misaligned  = 1'b0;
    be_start    = 4'b1111;
    wdata_start = alu_pass_i;
    case (f3[1:0])
      2'b00: begin
        be_start    = 4'b0001 << alu_y_i[1:0];
        wdata_start = {4{alu_pass_i[7:0]}};
      end
      2'b01: begin
        misaligned  = alu_y_i[0];
        be_start    = alu_y_i[1] ? 4'b1100 : 4'b0011;
        wdata_start = {2{alu_pass_i[15:0]}};
      end
      default: misaligned = |alu_y_i[1:0];
    endcase
  end

  always_comb begin
    byte_lane = mem_rdata_i[{addr_lo_q, 3'b000} +: 8];
    half_lane = addr_lo_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (funct3_q)
      3'b000:  load_val = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_val = {{16{half_lane[15]}}, half_lane};
      3'b100:  load_val = {24'b0, byte_lane};
      3'b101:  load_val = {16'b0, half_lane};
      default: load_val = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    wb_ok_d     = wb_ok_q;
    fault_d     = fault_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (stage_i == STAGE_MEM) begin
          funct3_d  = f3;
          addr_lo_d = alu_y_i[1:0];
          wb_rd_d   = ir_i[11:7];
          wb_ok_d   = 1'b0;
          fault_d   = 1'b0;
          cnt_d     = 8'd0;
          state_d   = FINISH;
          if (is_pass) begin
            wb_data_d = alu_y_i;
            wb_ok_d   = (ir_i[11:7] != 5'd0);
          end else if (is_load || is_store) begin
            if (!legal || misaligned) begin
              fault_d = 1'b1;
            end else begin
              mem_req_d   = 1'b1;
              mem_we_d    = is_store;
              mem_addr_d  = {alu_y_i[31:2], 2'b00};
              mem_be_d    = be_start;
              mem_wdata_d = wdata_start;
              state_d     = ACCESS;
            end
          end
        end
      end
      ACCESS: begin
        // Ack is checked first so that it wins over a coincident timeout.
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = FINISH;
          if (!mem_we_q) begin
            wb_data_d = load_val;
            wb_ok_d   = (wb_rd_q != 5'd0);
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TIMEOUT_CNT) begin
            mem_req_d = 1'b0;
            fault_d   = 1'b1;
            state_d   = FINISH;
          end
        end
      end
      FINISH: state_d = HOLD;
      HOLD: if (stage_i != STAGE_MEM) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'd0;
      wb_data_q   <= 32'd0;
      wb_rd_q     <= 5'd0;
      wb_ok_q     <= 1'b0;
      fault_q     <= 1'b0;
      funct3_q    <= 3'd0;
      addr_lo_q   <= 2'd0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      wb_ok_q     <= wb_ok_d;
      fault_q     <= fault_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_be_o    = mem_be_q;
  assign wb_data_o   = wb_data_q;
  assign wb_rd_o     = wb_rd_q;
  assign fault_o     = fault_q;
  assign done_o      = (state_q == FINISH);
  assign wb_en_o     = (state_q == FINISH) && wb_ok_q;
endmodule
